// File: rtl/bpu_seq_if.sv
// ---------------------------------------------------------------------------
// bpu_seq_if
//   Bus bundle between the BPU sequencer and its surroundings.
//   Groups three streams and the BPU-facing control lines:
//     weight in   : wgt_in_valid / wgt_in_data  -> wgt_in_ready
//     image in    : img_valid                   -> img_ready
//     result out  : out_valid / out_psum / out_bit <- out_ready
//     BPU control : bpu_instruction, bpu_wgt_en, bpu_wgt_input, bpu_height
//                   (outputs) and bpu_popcnt_add (accumulator readback)
//   Modports:
//     master : the sequencer side
//     slave  : the environment side (weight source, image source, sink, BPU)
// ---------------------------------------------------------------------------
interface bpu_seq_if;
   // weight row stream
   logic       wgt_in_valid;
   logic [6:0] wgt_in_data;
   logic       wgt_in_ready;
   // image window handshake (window data itself sits on the BPU img bus)
   logic       img_valid;
   logic       img_ready;
   // BPU control and accumulator readback
   logic [4:0] bpu_instruction;
   logic       bpu_wgt_en;
   logic [6:0] bpu_wgt_input;
   logic [2:0] bpu_height;
   logic [6:0] bpu_popcnt_add;
   // result stream
   logic       out_valid;
   logic       out_ready;
   logic [6:0] out_psum;
   logic       out_bit;

   modport master (
      input  wgt_in_valid, wgt_in_data, img_valid, bpu_popcnt_add, out_ready,
      output wgt_in_ready, img_ready, bpu_instruction, bpu_wgt_en,
             bpu_wgt_input, bpu_height, out_valid, out_psum, out_bit
   );

   modport slave (
      output wgt_in_valid, wgt_in_data, img_valid, bpu_popcnt_add, out_ready,
      input  wgt_in_ready, img_ready, bpu_instruction, bpu_wgt_en,
             bpu_wgt_input, bpu_height, out_valid, out_psum, out_bit
   );
endinterface

// File: rtl/bpu_seq.sv
// ---------------------------------------------------------------------------
// bpu_seq
//   Sequencer and result stage around one BPU 7x7 binary-convolution unit.
//   A job optionally loads 7 weight rows into the BPU, then for each of
//   NUM_PIX image windows issues psum-reset, one psum-add per row, captures
//   the signed accumulator, binarises it against a threshold and offers the
//   result downstream with a valid/ready handshake.
//
//   Parameters:
//     NUM_PIX : windows per job (1..1023)
//     CW      : pixel counter width, 2**CW > NUM_PIX
//
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     start      : job start pulse, honoured only when idle
//     height     : rows/cols per window (1..7), sampled at start
//     threshold  : signed binarisation threshold, sampled at start
//     reuse_wgt  : sampled at start; 1 skips the weight load
//     busy       : high whenever a job is in progress
//     done       : one-cycle pulse after the last result handshake
//     bus        : weight / image / result streams and BPU control
// ---------------------------------------------------------------------------
module bpu_seq #(
   parameter int NUM_PIX = 16,
   parameter int CW      = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] height,
   input  logic [6:0] threshold,
   input  logic       reuse_wgt,
   output logic       busy,
   output logic       done,
   bpu_seq_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOADW,
      S_CLR,
      S_ACC,
      S_CAP,
      S_OUT,
      S_FIN
   } state_t;

   // BPU instruction encoding: {psum_add, lut_sel[2:0], psum_rst}
   localparam logic [4:0] INSTR_NOP = 5'b00000;
   localparam logic [4:0] INSTR_CLR = 5'b00001;

   // Weight rows per load; the BPU shift register always takes all 7
   // rows no matter how many the window height actually uses.
   localparam logic [2:0] LAST_WGT = 3'd6;

   state_t        state_q, state_d;
   logic [2:0]    height_q, height_d;
   logic [6:0]    thr_q, thr_d;
   logic          reuse_q, reuse_d;
   logic [2:0]    wcnt_q, wcnt_d;
   logic [2:0]    row_q, row_d;
   logic [CW-1:0] pix_q, pix_d;
   logic          ov_q, ov_d;
   logic [6:0]    psum_q, psum_d;
   logic          bit_q, bit_d;

   logic [2:0]    last_row;
   logic [CW-1:0] pix_inc;

   // height_q is non-zero whenever ACC is reachable, so no underflow here
   assign last_row = height_q - 3'd1;
   assign pix_inc  = pix_q + CW'(1);

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         height_q <= '0;
         thr_q    <= '0;
         reuse_q  <= 1'b0;
         wcnt_q   <= '0;
         row_q    <= '0;
         pix_q    <= '0;
         ov_q     <= 1'b0;
         psum_q   <= '0;
         bit_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         height_q <= height_d;
         thr_q    <= thr_d;
         reuse_q  <= reuse_d;
         wcnt_q   <= wcnt_d;
         row_q    <= row_d;
         pix_q    <= pix_d;
         ov_q     <= ov_d;
         psum_q   <= psum_d;
         bit_q    <= bit_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and output decode
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      height_d = height_q;
      thr_d    = thr_q;
      reuse_d  = reuse_q;
      wcnt_d   = wcnt_q;
      row_d    = row_q;
      pix_d    = pix_q;
      ov_d     = ov_q;
      psum_d   = psum_q;
      bit_d    = bit_q;

      done                = 1'b0;
      bus.wgt_in_ready    = 1'b0;
      bus.bpu_wgt_en      = 1'b0;
      bus.bpu_wgt_input   = '0;
      bus.img_ready       = 1'b0;
      bus.bpu_instruction = INSTR_NOP;

      unique case (state_q)
         S_IDLE: begin
            // a zero-height window has no rows to sequence: drop the start
            if (start && (height != 3'd0)) begin
               height_d = height;
               thr_d    = threshold;
               reuse_d  = reuse_wgt;
               pix_d    = '0;
               wcnt_d   = '0;
               state_d  = reuse_wgt ? S_CLR : S_LOADW;
            end
         end

         S_LOADW: begin
            // weight rows flow straight through into the BPU shift register
            bus.wgt_in_ready  = 1'b1;
            bus.bpu_wgt_en    = bus.wgt_in_valid;
            bus.bpu_wgt_input = bus.wgt_in_data;
            if (bus.wgt_in_valid) begin
               if (wcnt_q == LAST_WGT) begin
                  wcnt_d  = '0;
                  state_d = S_CLR;
               end else begin
                  wcnt_d = wcnt_q + 3'd1;
               end
            end
         end

         S_CLR: begin
            // psum reset is held until a window shows up
            bus.bpu_instruction = INSTR_CLR;
            if (bus.img_valid) begin
               row_d   = '0;
               state_d = S_ACC;
            end
         end

         S_ACC: begin
            bus.bpu_instruction = {1'b1, row_q, 1'b0};
            row_d               = row_q + 3'd1;
            // the window is released on its last row; the BPU has already
            // sampled every row it needs by the end of this cycle
            if (row_q == last_row) begin
               bus.img_ready = 1'b1;
               state_d       = S_CAP;
            end
         end

         S_CAP: begin
            // accumulator now includes the final row's add
            psum_d  = bus.bpu_popcnt_add;
            bit_d   = ($signed(bus.bpu_popcnt_add) >= $signed(thr_q));
            ov_d    = 1'b1;
            state_d = S_OUT;
         end

         S_OUT: begin
            if (bus.out_ready) begin
               ov_d  = 1'b0;
               pix_d = pix_inc;
               if (pix_inc == CW'(NUM_PIX)) state_d = S_FIN;
               else                         state_d = S_CLR;
            end
         end

         S_FIN: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign busy           = (state_q != S_IDLE);
   assign bus.bpu_height = height_q;
   assign bus.out_valid  = ov_q;
   assign bus.out_psum   = psum_q;
   assign bus.out_bit    = bit_q;

endmodule

// File: tb/tb_bpu_seq.sv
// ---------------------------------------------------------------------------
// tb_bpu_seq
//   Drives bpu_seq with a stub BPU accumulator and random weight / image /
//   ready traffic. A transaction-level model (queues of expected instruction
//   words and results, a weight-beat budget, job bookkeeping) predicts every
//   output each cycle; a few directed phases pin the model with literals.
// ---------------------------------------------------------------------------
module tb_bpu_seq;
   localparam int NUM_PIX = 3;
   localparam int CW      = 4;

   logic       clk = 1'b0;
   logic       rst, start, reuse_wgt, busy, done;
   logic [2:0] height;
   logic [6:0] threshold;

   bpu_seq_if bus();

   bpu_seq #(.NUM_PIX(NUM_PIX), .CW(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .height(height),
      .threshold(threshold), .reuse_wgt(reuse_wgt), .busy(busy),
      .done(done), .bus(bus)
   );

   always #5 clk = ~clk;

   // ---------------- stub BPU: per-row contribution of the current window
   int               contrib [8];
   logic signed [6:0] acc;

   always_ff @(posedge clk) begin
      if (bus.bpu_instruction[0])      acc <= '0;
      else if (bus.bpu_instruction[4]) acc <= acc + 7'(contrib[bus.bpu_instruction[3:1]]);
   end
   assign bus.bpu_popcnt_add = acc;

   // ---------------- bookkeeping
   int checks = 0, errors = 0, cyc = 0;
   int wen_cnt = 0;
   bit img_hs = 0;
   bit img_en = 0;
   int rdy_mode = 1;   // 0 random, 1 held low, 2 held high

   // model state
   bit m_busy = 0, m_fin = 0;
   int m_height = 0, m_thr = 0, m_load_left = 0, m_hs = 0, m_ov_due = 0;
   int iq[$];
   int rq_psum[$];
   int rq_bit[$];

   // snapshots of the last negedge sample
   int s_busy, s_done, s_ov, s_psum, s_bit, s_instr, s_irdy, s_wrdy, s_wen, s_height;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_step();
      bit m_clr, eov, st_ok, fin_n;
      int ei, s;
      cyc++;
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_fin));
      chk("bpu_height", int'(bus.bpu_height), m_height);
      chk("wgt_in_ready", int'(bus.wgt_in_ready), int'(m_load_left > 0));
      chk("bpu_wgt_en", int'(bus.bpu_wgt_en), int'((m_load_left > 0) && bus.wgt_in_valid));
      chk("bpu_wgt_input", int'(bus.bpu_wgt_input),
          (m_load_left > 0) ? int'(bus.wgt_in_data) : 0);
      m_clr = m_busy && (m_load_left == 0) && (iq.size() == 0) &&
              (rq_psum.size() == 0) && !m_fin;
      ei = (iq.size() > 0) ? iq[0] : (m_clr ? 1 : 0);
      chk("bpu_instruction", int'(bus.bpu_instruction), ei);
      chk("img_ready", int'(bus.img_ready), int'(iq.size() == 2));
      eov = (rq_psum.size() > 0) && (cyc >= m_ov_due);
      chk("out_valid", int'(bus.out_valid), int'(eov));
      if (eov) begin
         chk("out_psum", int'(bus.out_psum), rq_psum[0]);
         chk("out_bit", int'(bus.out_bit), rq_bit[0]);
      end
      if (bus.bpu_wgt_en) wen_cnt++;
      img_hs   = bus.img_valid && bus.img_ready;
      s_busy   = int'(busy);            s_done  = int'(done);
      s_ov     = int'(bus.out_valid);   s_psum  = int'(bus.out_psum);
      s_bit    = int'(bus.out_bit);     s_instr = int'(bus.bpu_instruction);
      s_irdy   = int'(bus.img_ready);   s_wrdy  = int'(bus.wgt_in_ready);
      s_wen    = int'(bus.bpu_wgt_en);  s_height = int'(bus.bpu_height);

      // advance the model to the next cycle
      st_ok = start && !m_busy && (height != 3'd0);
      fin_n = 0;
      if ((m_load_left > 0) && bus.wgt_in_valid) m_load_left--;
      if (iq.size() > 0) begin
         if (iq.size() == 2) begin
            s = 0;
            for (int r = 0; r < m_height; r++) s += contrib[r];
            rq_psum.push_back(s & 127);
            rq_bit.push_back(int'(s >= m_thr));
         end
         void'(iq.pop_front());
      end else if (m_clr && bus.img_valid) begin
         for (int r = 0; r < m_height; r++) iq.push_back(16 + 2 * r);
         iq.push_back(0);
         m_ov_due = cyc + m_height + 2;
      end
      if (eov && bus.out_ready) begin
         void'(rq_psum.pop_front());
         void'(rq_bit.pop_front());
         m_hs++;
         if (m_hs == NUM_PIX) fin_n = 1;
      end
      if (m_fin) begin
         m_fin  = 0;
         m_busy = 0;
      end
      if (fin_n) m_fin = 1;
      if (st_ok) begin
         m_busy      = 1;
         m_height    = int'(height);
         m_thr       = int'($signed(threshold));
         m_load_left = reuse_wgt ? 0 : 7;
         m_hs        = 0;
      end
      if (rst) begin
         m_busy = 0; m_fin = 0; m_height = 0; m_load_left = 0; m_hs = 0;
         iq.delete(); rq_psum.delete(); rq_bit.delete();
      end
   endtask

   task automatic new_window();
      for (int r = 0; r < 8; r++) contrib[r] = int'($urandom_range(0, 18)) - 9;
   endtask

   task automatic drive();
      bus.wgt_in_valid = ($urandom_range(0, 2) != 0);
      bus.wgt_in_data  = 7'($urandom_range(0, 127));
      if (img_hs) begin
         new_window();
         bus.img_valid = img_en && ($urandom_range(0, 1) == 1);
      end else if (!bus.img_valid) begin
         bus.img_valid = img_en && ($urandom_range(0, 2) != 0);
      end
      case (rdy_mode)
         1:       bus.out_ready = 1'b0;
         2:       bus.out_ready = 1'b1;
         default: bus.out_ready = ($urandom_range(0, 1) == 1);
      endcase
   endtask

   task automatic cycle();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic wait_done(input int lim);
      bit got = 0;
      for (int i = 0; i < lim && !got; i++) begin
         cycle();
         if (s_done == 1) got = 1;
      end
      chk("done_seen", int'(got), 1);
   endtask

   task automatic set_win_m1();
      for (int r = 0; r < 8; r++) contrib[r] = (r < 3) ? -1 : 5;
   endtask

   int exp_seq [5] = '{1, 16, 18, 20, 0};
   int exp_rdy [5] = '{0, 0, 0, 1, 0};

   initial begin
      bit hit;
      rst = 1'b1; start = 1'b0; height = '0; threshold = '0; reuse_wgt = 1'b0;
      bus.img_valid = 1'b0; bus.out_ready = 1'b0;
      bus.wgt_in_valid = 1'b0; bus.wgt_in_data = '0;
      new_window();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset state
      cycle();
      chk("rst_busy", s_busy, 0);
      chk("rst_out_valid", s_ov, 0);
      chk("rst_instr", s_instr, 0);
      chk("rst_psum", s_psum, 0);
      chk("rst_height", s_height, 0);

      // zero-height start is ignored
      height = 3'd0; start = 1'b1;
      cycle();
      start = 1'b0;
      cycle();
      chk("h0_busy", s_busy, 0);

      // job A: weight load with gaps, then instruction stream and backpressure
      set_win_m1();
      height = 3'd3; threshold = 7'h7D; reuse_wgt = 1'b0; rdy_mode = 1; img_en = 0;
      start = 1'b1;
      cycle();
      start = 1'b0;
      height = 3'd7; start = 1'b1;   // ignored while busy
      cycle();
      start = 1'b0;
      cycle();
      chk("height_held", s_height, 3);
      for (int i = 0; i < 100 && s_wrdy == 1; i++) cycle();
      chk("wgt_beats", wen_cnt, 7);
      chk("clr_after_load", s_instr, 1);
      img_en = 1; bus.img_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("instr_seq", s_instr, exp_seq[k]);
         chk("img_ready_seq", s_irdy, exp_rdy[k]);
      end
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("bp_valid", s_ov, 1);
         chk("bp_psum", s_psum, 'h7D);
         chk("bp_bit", s_bit, 1);
         chk("bp_no_clr", s_instr, 0);
      end
      rdy_mode = 0;
      wait_done(2000);

      // job B: reuse weights, threshold just above the sum
      img_en = 0; bus.img_valid = 1'b0;
      set_win_m1();
      height = 3'd3; threshold = 7'h7E; reuse_wgt = 1'b1; rdy_mode = 1;
      start = 1'b1;
      cycle();
      start = 1'b0;
      img_en = 1; bus.img_valid = 1'b1;
      hit = 0;
      for (int i = 0; i < 50 && !hit; i++) begin
         cycle();
         if (s_ov == 1) hit = 1;
      end
      chk("b_valid_seen", int'(hit), 1);
      chk("b_psum", s_psum, 'h7D);
      chk("b_bit", s_bit, 0);
      rdy_mode = 0;
      wait_done(2000);
      cycle();
      chk("b_busy_after_done", s_busy, 0);
      chk("b_no_reload", wen_cnt, 7);

      // job C: reset during ACC row 1
      height = 3'd5; threshold = 7'h00; reuse_wgt = 1'b1; rdy_mode = 2;
      start = 1'b1;
      cycle();
      start = 1'b0;
      img_en = 1; bus.img_valid = 1'b1;
      hit = 0;
      for (int i = 0; i < 50 && !hit; i++) begin
         cycle();
         if (s_instr == 16) hit = 1;
      end
      chk("c_acc_seen", int'(hit), 1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      cycle();
      chk("c_busy", s_busy, 0);
      chk("c_done", s_done, 0);
      chk("c_out_valid", s_ov, 0);
      chk("c_instr", s_instr, 0);
      chk("c_img_ready", s_irdy, 0);
      chk("c_wgt_ready", s_wrdy, 0);
      chk("c_wgt_en", s_wen, 0);
      chk("c_height", s_height, 0);
      chk("c_psum", s_psum, 0);
      chk("c_bit", s_bit, 0);

      // random jobs
      for (int j = 0; j < 12; j++) begin
         height    = 3'($urandom_range(1, 7));
         threshold = 7'(int'($urandom_range(0, 30)) - 15);
         reuse_wgt = ($urandom_range(0, 1) == 1);
         rdy_mode  = ($urandom_range(0, 1) == 1) ? 2 : 0;
         img_en    = 1;
         start = 1'b1;
         cycle();
         start = 1'b0;
         wait_done(3000);
         repeat (2) cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
